// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone burst master.
// Holds CTI encodings, the controller state enum and the latched burst descriptor.
package wb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        BUS  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Per-request attributes captured at the request handshake.
    typedef struct packed {
        logic             we;
        logic [LEN_W-1:0] len;
    } burst_t;

    // Cycle type for a beat: classic for single beats, end-of-burst on the last one.
    function automatic logic [2:0] cti_for(input logic [LEN_W-1:0] len,
                                           input logic [LEN_W-1:0] beat);
        if (len == '0) begin
            return CTI_CLASSIC;
        end else if (beat == len) begin
            return CTI_EOB;
        end else begin
            return CTI_INCR;
        end
    endfunction

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone burst master: runs 1..8 beat incrementing reads or writes for a client,
// with bounded retry after RTY, abort on ERR and a one-cycle completion pulse.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int unsigned RETRY_GAP = 4,
    parameter int unsigned MAX_RETRY = 7
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_len,

    input  logic [31:0] wdat,
    input  logic        wdat_valid,
    output logic        wdat_ready,
    output logic [31:0] rdat,
    output logic        rdat_valid,
    output logic        rdat_last,

    output logic        done,
    output logic        done_err,

    output logic        CYC,
    output logic        STB,
    output logic        WE,
    output logic [31:0] ADR,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic [2:0]  CTI_O,
    input  logic        ACK,
    input  logic        ERR,
    input  logic        RTY
);

    state_e              state_q, state_d;
    burst_t              burst_q, burst_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [2:0]          cti_q, cti_d;
    logic                cyc_q, cyc_d;
    logic                req_ready_q, req_ready_d;
    logic                wdat_ready_q, wdat_ready_d;
    logic                done_q, done_d;
    logic                done_err_q, done_err_d;

    logic                last_beat;
    logic                ack_only;
    logic                unused_addr_lsb;

    assign last_beat       = (beat_q == burst_q.len);
    assign ack_only        = (state_q == BUS) && ACK && !ERR && !RTY;
    assign unused_addr_lsb = ^req_addr[1:0];

    // Next-state and next-output logic; response priority is ERR > RTY > ACK.
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        retry_d    = retry_q;
        gap_d      = gap_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        cti_d      = cti_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    adr_d       = {req_addr[ADDR_W-1:2], 2'b00};
                    burst_d.we  = req_we;
                    burst_d.len = req_len;
                    beat_d      = '0;
                    retry_d     = '0;
                    cti_d       = cti_for(req_len, LEN_W'(0));
                    state_d     = req_we ? LOAD : BUS;
                end
            end
            LOAD: begin
                if (wdat_valid && wdat_ready_q) begin
                    dat_d   = wdat;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (ERR) begin
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                    state_d    = DONE;
                end else if (RTY) begin
                    if (retry_q == CNT_W'(MAX_RETRY)) begin
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        retry_d = retry_q + CNT_W'(1);
                        gap_d   = CNT_W'(RETRY_GAP - 1);
                        state_d = GAP;
                    end
                end else if (ACK) begin
                    adr_d  = adr_q + ADDR_W'(4);
                    beat_d = beat_q + LEN_W'(1);
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cti_d   = cti_for(burst_q.len, beat_d);
                        state_d = burst_q.we ? LOAD : BUS;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = BUS;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cyc_d        = (state_d == BUS);
        req_ready_d  = (state_d == IDLE);
        wdat_ready_d = (state_d == LOAD);
    end

    // State and registered outputs; reset drops the bus immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            beat_q       <= '0;
            retry_q      <= '0;
            gap_q        <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            cti_q        <= CTI_CLASSIC;
            cyc_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            wdat_ready_q <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            beat_q       <= beat_d;
            retry_q      <= retry_d;
            gap_q        <= gap_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            cti_q        <= cti_d;
            cyc_q        <= cyc_d;
            req_ready_q  <= req_ready_d;
            wdat_ready_q <= wdat_ready_d;
            done_q       <= done_d;
            done_err_q   <= done_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign wdat_ready = wdat_ready_q;
    assign done       = done_q;
    assign done_err   = done_err_q;

    assign CYC   = cyc_q;
    assign STB   = cyc_q;
    assign WE    = burst_q.we;
    assign ADR   = adr_q;
    assign DAT_O = dat_q;
    assign CTI_O = cti_q;

    // Read data passes straight through in the ACK cycle; the client cannot stall it.
    assign rdat       = DAT_I;
    assign rdat_valid = ack_only && !burst_q.we;
    assign rdat_last  = rdat_valid && last_beat;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: scripted and randomized bursts against a beat-level
// protocol model of what the master must present and report.
module tb_wb_burst_master;

    localparam int RG = 4;
    localparam int MR = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_len;
    logic [31:0] wdat;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] rdat;
    logic        rdat_valid;
    logic        rdat_last;
    logic        done;
    logic        done_err;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] ADR;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic [2:0]  CTI_O;
    logic        ACK;
    logic        ERR;
    logic        RTY;

    int checks = 0;
    int errors = 0;

    wb_burst_master #(
        .RETRY_GAP(RG),
        .MAX_RETRY(MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_len   (req_len),
        .wdat      (wdat),
        .wdat_valid(wdat_valid),
        .wdat_ready(wdat_ready),
        .rdat      (rdat),
        .rdat_valid(rdat_valid),
        .rdat_last (rdat_last),
        .done      (done),
        .done_err  (done_err),
        .CYC       (CYC),
        .STB       (STB),
        .WE        (WE),
        .ADR       (ADR),
        .DAT_O     (DAT_O),
        .DAT_I     (DAT_I),
        .CTI_O     (CTI_O),
        .ACK       (ACK),
        .ERR       (ERR),
        .RTY       (RTY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One burst, acting as client and slave. mode: 0 always ACK, 1 random,
    // 2 always RTY, 3 ERR+ACK on beat sel, 4 one RTY on beat sel.
    task automatic run_burst(input logic [31:0] a, input logic w, input logic [2:0] l,
                             input int mode, input int sel, input logic [31:0] w0,
                             output int n_rty, output int n_rd, output logic got_err,
                             output logic [31:0] end_adr);
        logic [31:0] base;
        logic [31:0] wd [8];
        logic [31:0] dv;
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        logic        ra, rr, re, exp_rv, exp_err, finished, rty_used;
        int          beats, k, nr, ph, gap_left, p;
        base = {a[31:2], 2'b00};
        beats = int'(l) + 1;
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        wd[0] = w0;
        k = 0; nr = 0; gap_left = 0; n_rty = 0; n_rd = 0;
        exp_err = 1'b0; finished = 1'b0; rty_used = 1'b0; got_err = 1'b0; end_adr = '0;
        ph = w ? 0 : 1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_idle: got %b exp 1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_we = w; req_len = l;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom); req_len = 3'($urandom);
        for (int c = 0; c < 600 && !finished; c++) begin
            exp_adr = base + 32'(4 * k);
            if (ph != 3) begin
                checks++;
                if ({done, done_err} !== 2'b00) begin
                    errors++; $display("FAIL early_done: got %b exp 00", {done, done_err});
                end
            end
            req_valid = (mode == 1 && ph != 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (ph)
                0: begin
                    checks++;
                    if ({CYC, STB, wdat_ready} !== 3'b001) begin
                        errors++; $display("FAIL load_phase: got %b exp 001", {CYC, STB, wdat_ready});
                    end
                    if (mode != 1 || $urandom_range(0, 2) != 0) begin
                        wdat_valid = 1'b1; wdat = wd[k]; ph = 1;
                    end
                end
                1: begin
                    exp_cti = (beats == 1) ? 3'b000 : ((k == beats - 1) ? 3'b111 : 3'b010);
                    checks++;
                    if ({CYC, STB, WE, wdat_ready} !== {1'b1, 1'b1, w, 1'b0}) begin
                        errors++; $display("FAIL bus_ctrl: got %b exp %b", {CYC, STB, WE, wdat_ready}, {1'b1, 1'b1, w, 1'b0});
                    end
                    checks++;
                    if (ADR !== exp_adr) begin
                        errors++; $display("FAIL bus_adr beat %0d: got %h exp %h", k, ADR, exp_adr);
                    end
                    checks++;
                    if (CTI_O !== exp_cti) begin
                        errors++; $display("FAIL bus_cti beat %0d: got %b exp %b", k, CTI_O, exp_cti);
                    end
                    if (w) begin
                        checks++;
                        if (DAT_O !== wd[k]) begin
                            errors++; $display("FAIL bus_dat_o beat %0d: got %h exp %h", k, DAT_O, wd[k]);
                        end
                    end
                    ra = 1'b0; rr = 1'b0; re = 1'b0;
                    case (mode)
                        0: ra = 1'b1;
                        2: rr = 1'b1;
                        3: begin ra = 1'b1; re = (k == sel); end
                        4: begin
                            if (k == sel && !rty_used) begin rr = 1'b1; rty_used = 1'b1; end
                            else ra = 1'b1;
                        end
                        default: begin
                            p = int'($urandom_range(0, 99));
                            if (p < 15) begin
                                ra = 1'b0;
                            end else if (p < 27) begin
                                rr = 1'b1; ra = 1'($urandom_range(0, 1));
                            end else if (p < 31) begin
                                re = 1'b1; ra = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
                            end else begin
                                ra = 1'b1;
                            end
                        end
                    endcase
                    dv = $urandom;
                    DAT_I = dv; ACK = ra; RTY = rr; ERR = re;
                    #1;
                    exp_rv = ra & ~rr & ~re & ~w;
                    checks++;
                    if (rdat_valid !== exp_rv) begin
                        errors++; $display("FAIL rdat_valid beat %0d: got %b exp %b", k, rdat_valid, exp_rv);
                    end
                    if (exp_rv) begin
                        n_rd++;
                        checks++;
                        if ({rdat_last, rdat} !== {(k == beats - 1), dv}) begin
                            errors++; $display("FAIL rdat beat %0d: got %b/%h exp %b/%h", k, rdat_last, rdat, (k == beats - 1), dv);
                        end
                    end
                    if (re) begin
                        exp_err = 1'b1; ph = 3;
                    end else if (rr) begin
                        n_rty++;
                        if (nr == MR) begin
                            exp_err = 1'b1; ph = 3;
                        end else begin
                            nr++; gap_left = RG; ph = 2;
                        end
                    end else if (ra) begin
                        k++;
                        ph = (k == beats) ? 3 : (w ? 0 : 1);
                    end
                end
                2: begin
                    checks++;
                    if ({CYC, STB, wdat_ready, rdat_valid} !== 4'b0000) begin
                        errors++; $display("FAIL retry_gap: got %b exp 0000", {CYC, STB, wdat_ready, rdat_valid});
                    end
                    gap_left--;
                    if (gap_left == 0) ph = 1;
                end
                default: begin
                    checks++;
                    if ({done, done_err, CYC} !== {1'b1, exp_err, 1'b0}) begin
                        errors++; $display("FAIL done_pulse: got %b exp %b", {done, done_err, CYC}, {1'b1, exp_err, 1'b0});
                    end
                    checks++;
                    if (ADR !== exp_adr) begin
                        errors++; $display("FAIL done_adr: got %h exp %h", ADR, exp_adr);
                    end
                    got_err = done_err; end_adr = ADR; finished = 1'b1;
                end
            endcase
            @(posedge clk); #1;
            ACK = 1'b0; RTY = 1'b0; ERR = 1'b0; wdat_valid = 1'b0;
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL burst_timeout: got no done exp done within 600 cycles");
        end
        checks++;
        if ({done, req_ready} !== 2'b01) begin
            errors++; $display("FAIL idle_return: got %b exp 01", {done, req_ready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        checks++;
        if (CYC !== 1'b0) begin
            errors++; $display("FAIL reset_async_cyc: got %b exp 0", CYC);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({CYC, STB, WE, req_ready, wdat_ready, rdat_valid, rdat_last, done, done_err} !== 9'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 0", {CYC, STB, WE, req_ready, wdat_ready, rdat_valid, rdat_last, done, done_err});
        end
        checks++;
        if ({ADR, DAT_O} !== 64'h0) begin
            errors++; $display("FAIL reset_bus: got %h exp 0", {ADR, DAT_O});
        end
        checks++;
        if (CTI_O !== 3'b000) begin
            errors++; $display("FAIL reset_cti: got %b exp 000", CTI_O);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, CYC} !== 2'b10) begin
            errors++; $display("FAIL reset_release: got %b exp 10", {req_ready, CYC});
        end
    endtask

    task automatic test_read_burst();
        int nrty, nrd; logic e; logic [31:0] ea;
        run_burst(32'h0000_1000, 1'b0, 3'd3, 0, 0, 32'h0, nrty, nrd, e, ea);
        checks++;
        if ({nrd, e} !== {32'd4, 1'b0}) begin
            errors++; $display("FAIL read_burst_summary: got rd=%0d err=%b exp rd=4 err=0", nrd, e);
        end
    endtask

    task automatic test_single_write();
        int nrty, nrd; logic e; logic [31:0] ea;
        run_burst(32'h0000_2003, 1'b1, 3'd0, 0, 0, 32'hDEAD_BEEF, nrty, nrd, e, ea);
        checks++;
        if ({nrd, e, ea} !== {32'd0, 1'b0, 32'h0000_2004}) begin
            errors++; $display("FAIL single_write_summary: got rd=%0d err=%b adr=%h exp rd=0 err=0 adr=00002004", nrd, e, ea);
        end
    endtask

    task automatic test_retry();
        int nrty, nrd; logic e; logic [31:0] ea;
        run_burst($urandom, 1'b0, 3'd1, 4, 0, 32'h0, nrty, nrd, e, ea);
        checks++;
        if ({nrty, nrd, e} !== {32'd1, 32'd2, 1'b0}) begin
            errors++; $display("FAIL retry_summary: got rty=%0d rd=%0d err=%b exp rty=1 rd=2 err=0", nrty, nrd, e);
        end
        run_burst($urandom, 1'b1, 3'd2, 4, 1, $urandom, nrty, nrd, e, ea);
        checks++;
        if ({nrty, e} !== {32'd1, 1'b0}) begin
            errors++; $display("FAIL retry_write_summary: got rty=%0d err=%b exp rty=1 err=0", nrty, e);
        end
    endtask

    task automatic test_retry_abort();
        int nrty, nrd; logic e; logic [31:0] ea;
        run_burst($urandom, 1'b0, 3'($urandom), 2, 0, 32'h0, nrty, nrd, e, ea);
        checks++;
        if ({nrty, nrd, e} !== {32'd3, 32'd0, 1'b1}) begin
            errors++; $display("FAIL retry_abort_rd: got rty=%0d rd=%0d err=%b exp rty=3 rd=0 err=1", nrty, nrd, e);
        end
        run_burst($urandom, 1'b1, 3'd0, 2, 0, $urandom, nrty, nrd, e, ea);
        checks++;
        if ({nrty, e} !== {32'd3, 1'b1}) begin
            errors++; $display("FAIL retry_abort_wr: got rty=%0d err=%b exp rty=3 err=1", nrty, e);
        end
    endtask

    task automatic test_err_priority();
        int nrty, nrd; logic e; logic [31:0] ea;
        run_burst(32'h0000_4000, 1'b0, 3'd7, 3, 2, 32'h0, nrty, nrd, e, ea);
        checks++;
        if ({nrd, e, ea} !== {32'd2, 1'b1, 32'h0000_4008}) begin
            errors++; $display("FAIL err_priority: got rd=%0d err=%b adr=%h exp rd=2 err=1 adr=00004008", nrd, e, ea);
        end
    endtask

    task automatic test_random();
        int nrty, nrd; logic e; logic [31:0] ea;
        for (int i = 0; i < 40; i++) begin
            run_burst($urandom, 1'($urandom), 3'($urandom), 1, 0, $urandom, nrty, nrd, e, ea);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] exp_adr;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_start: got %b exp 1", req_ready);
        end
        req_valid = 1'b1; req_addr = 32'hFFFF_FFF8; req_we = 1'b0; req_len = 3'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            exp_adr = 32'hFFFF_FFF8 + 32'(4 * b);
            checks++;
            if ({CYC, ADR} !== {1'b1, exp_adr}) begin
                errors++; $display("FAIL wrap_adr beat %0d: got %b/%h exp 1/%h", b, CYC, ADR, exp_adr);
            end
            if (b < 2) begin
                ACK = 1'b1; DAT_I = $urandom;
                @(posedge clk); #1;
                ACK = 1'b0;
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({CYC, STB, done} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_async: got %b exp 000", {CYC, STB, done});
        end
        @(posedge clk); #1;
        checks++;
        if ({CYC, done, done_err} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_hold: got %b exp 000", {CYC, done, done_err});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, done, CYC} !== 3'b100) begin
            errors++; $display("FAIL mid_reset_release: got %b exp 100", {req_ready, done, CYC});
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_len = '0;
        wdat = '0; wdat_valid = 1'b0; DAT_I = '0; ACK = 1'b0; ERR = 1'b0; RTY = 1'b0;
        test_reset();
        test_read_burst();
        test_single_write();
        test_retry();
        test_retry_abort();
        test_err_priority();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 The block SHALL have parameter RETRY_GAP, default 4, meaning idle cycles with CYC low after a RTY before the beat is re-issued (1..15).
REQ-002 The block SHALL have parameter MAX_RETRY, default 7, meaning RTY responses tolerated per request before aborting (0..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (system clock, all logic on rising edge); rst input 1 (asynchronous reset, active-low).
REQ-004 Client request ports SHALL be: req_valid in 1 (request present); req_ready out 1 (accepting); req_addr in 32 (start byte address); req_we in 1 (1=write); req_len in 3 (beats minus one, 1..8 beats).
REQ-005 Client data ports SHALL be: wdat in 32 (write beat); wdat_valid in 1; wdat_ready out 1 (beat loaded); rdat out 32 (read beat); rdat_valid out 1; rdat_last out 1 (final read beat).
REQ-006 Completion ports SHALL be: done out 1 (one-cycle completion pulse); done_err out 1 (valid with done, 1=aborted).
REQ-007 Wishbone master ports SHALL be: CYC out 1; STB out 1; WE out 1; ADR out 32; DAT_O out 32 (master write data); DAT_I in 32 (slave read data); CTI_O out 3; ACK in 1; ERR in 1; RTY in 1.

Function
REQ-008 States SHALL be IDLE, LOAD, BUS, GAP, DONE; req_ready=1 only in IDLE.
REQ-009 req_valid&&req_ready SHALL latch addr with bits[1:0] forced 0, we, beats=req_len+1, clear beat and retry counters, go to LOAD (write) or BUS (read).
REQ-010 LOAD: wdat_ready=1; on wdat_valid, DAT_O<=wdat, go BUS next cycle with CYC=STB=1; CYC/STB stay 0 while waiting.
REQ-011 BUS: CYC=STB=1, WE=latched we, ADR=current address, held stable until a slave response.
REQ-012 CTI_O SHALL be 3'b000 for 1-beat requests, 3'b010 for every non-final beat, 3'b111 for the final beat of multi-beat requests.
REQ-013 Response priority SHALL be ERR > RTY > ACK when asserted together.
REQ-014 ACK: address+=4 (32-bit wrap, 0xFFFFFFFC->0x00000000), beat counter+1; read drives rdat=DAT_I, rdat_valid=1 in the ACK cycle (zero latency, no backpressure), rdat_last=1 on the final beat.
REQ-015 After a non-final ACK, reads SHALL keep STB=1 with next address the following cycle; writes SHALL return to LOAD, dropping CYC and STB.
REQ-016 After the final ACK the block SHALL enter DONE: done=1, done_err=0 for one cycle, then IDLE.
REQ-017 ERR: drop CYC/STB next cycle, no rdat_valid, DONE with done_err=1; remaining beats discarded.
REQ-018 RTY: retry counter+1; if counter was already MAX_RETRY, DONE with done_err=1; else GAP.
REQ-019 GAP: CYC=STB=0 for exactly RETRY_GAP cycles, then BUS re-issues the same beat with unchanged ADR, DAT_O, CTI_O; write data not re-requested.
REQ-020 Retry counter SHALL count per request, not reset by ACK.
REQ-021 wdat_ready and rdat_valid SHALL be 0 outside LOAD and ACK cycles respectively; req_* ignored outside IDLE.

Reset
REQ-022 While rst=0: CYC, STB, WE, req_ready, wdat_ready, rdat_valid, rdat_last, done, done_err=0; ADR, DAT_O=0; CTI_O=3'b000; state=IDLE; counters 0.
REQ-023 Reset asserted mid-burst SHALL drop CYC/STB immediately (asynchronously), no done pulse; first IDLE cycle after release has req_ready=1.

Structure
REQ-024 Package wb_pkg SHALL hold CTI constants (CTI_CLASSIC 3'b000, CTI_INCR 3'b010, CTI_EOB 3'b111) and the state enum.
REQ-025 Single module, no sub-modules; registered Wishbone outputs except rdat/rdat_valid/rdat_last (combinational from ACK/DAT_I).

Verification
REQ-026 Read len=3 at 0x1000, slave ACKs every cycle -> ADR 0x1000..0x100C on 4 consecutive cycles, CTI 010,010,010,111, 4 rdat_valid, rdat_last on 4th, done=1 done_err=0.
REQ-027 Write len=0 at 0x2003, wdat=0xDEADBEEF -> ADR=0x2000, CTI=000, WE=1, DAT_O=0xDEADBEEF until ACK, one done.
REQ-028 Read len=1, RTY on beat 1 -> CYC low exactly 4 cycles, beat 1 re-issued at same ADR, completes done_err=0.
REQ-029 MAX_RETRY=2, slave always RTY -> 3 RTY seen, then done=1 done_err=1, CYC=0.
REQ-030 Read len=7, ERR+ACK together on beat 3 -> no rdat_valid that cycle, done_err=1, ADR not incremented.
REQ-031 Read len=7 at 0xFFFFFFF8, rst=0 after 2 ACKs -> ADR wraps to 0x00000000 on beat 3; reset forces CYC=0 same cycle, no done.
